bn_act_pack: RTL and testbench

Post-normalisation stage sitting directly downstream of the batch-norm unit. It consumes the per-lane BN result stream and applies optional ReLU, an arithmetic right-shift requantisation and saturation to the output precision. Results are packed into fixed-width words. A small output queue presents them to the output-buffer writer over a valid/ready handshake. The BN unit cannot stall, so this block absorbs short writer back-pressure and flags any loss.

---
 rtl/bn_act_pkg.sv | 23 ++
 rtl/bn_act_pack_if.sv | 11 +
 rtl/act_pack_fifo.sv | 71 +++++++
 rtl/bn_act_pack.sv | 152 +++++++++++++++
 tb/tb_bn_act_pack.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bn_act_pkg.sv
// Shared constants and types for the BN post-processing / packing stage.
package bn_act_pkg;

    localparam int BN_DATA_WIDTH_DEF  = 16;
    localparam int OUT_DATA_WIDTH_DEF = 8;
    localparam int PACK_NUM_DEF       = 4;
    localparam int SHIFT_WIDTH_DEF    = 5;
    localparam int FIFO_DEPTH_DEF     = 2;

    function automatic int sat_max(input int width);
        return (1 <<< (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 <<< (width - 1));
    endfunction

    localparam int SAT_MAX_DEF = sat_max(OUT_DATA_WIDTH_DEF);
    localparam int SAT_MIN_DEF = sat_min(OUT_DATA_WIDTH_DEF);

    typedef logic [OUT_DATA_WIDTH_DEF*PACK_NUM_DEF-1:0] pack_word_t;

endpackage

// File: rtl/bn_act_pack_if.sv
// Packed-word valid/ready stream from bn_act_pack to the output-buffer writer.
interface bn_act_pack_if #(
    parameter int WORD_WIDTH = 32
) ();
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/act_pack_fifo.sv
// Small synchronous queue with registered storage; a push into a full queue
// is still accepted when a pop happens in the same cycle.
module act_pack_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bn_act_pack.sv
// ReLU, arithmetic-shift requantisation, saturation and lane packing of the BN stream.
// Define BN_ACT_PACK_ROUND_EN for round-half-up before the shift (default: floor).
module bn_act_pack
    import bn_act_pkg::*;
#(
    parameter int BN_DATA_WIDTH  = BN_DATA_WIDTH_DEF,
    parameter int OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF,
    parameter int PACK_NUM       = PACK_NUM_DEF,
    parameter int SHIFT_WIDTH    = SHIFT_WIDTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [BN_DATA_WIDTH-1:0] bn_output_data,
    input  logic                            bn_result_valid,
    input  logic                            relu_enable_layer,
    input  logic [SHIFT_WIDTH-1:0]          quant_shift,
    input  logic                            layer_start,
    input  logic                            flush,
    bn_act_pack_if.master                   out_if,
    output logic                            overflow
);
    localparam int EW = BN_DATA_WIDTH + 1;
    localparam int WW = OUT_DATA_WIDTH * PACK_NUM;
    localparam int CW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic signed [EW-1:0] SAT_MAX = EW'(sat_max(OUT_DATA_WIDTH));
    localparam logic signed [EW-1:0] SAT_MIN = EW'(sat_min(OUT_DATA_WIDTH));

    logic signed [OUT_DATA_WIDTH-1:0] q_q, q_d;
    logic                             q_valid_q, q_valid_d;
    logic signed [EW-1:0]             v_ext, r_ext, rnd;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [WW-1:0]                    word_q, word_d, filled;
    logic                             overflow_q, overflow_d;
    logic                             push;
    logic [WW-1:0]                    push_word;
    logic                             fifo_pop, fifo_empty, fifo_full;
    logic [WW-1:0]                    fifo_dout;

    always_comb begin
        v_ext = {bn_output_data[BN_DATA_WIDTH-1], bn_output_data};
        if (relu_enable_layer && bn_output_data[BN_DATA_WIDTH-1]) begin
            v_ext = '0;
        end
        rnd = '0;
`ifdef BN_ACT_PACK_ROUND_EN
        // Shifts wider than the data round every representable input to zero.
        if (quant_shift == '0) begin
            r_ext = v_ext;
        end else if (int'(quant_shift) > BN_DATA_WIDTH) begin
            r_ext = '0;
        end else begin
            rnd   = EW'(1) << (quant_shift - SHIFT_WIDTH'(1));
            r_ext = (v_ext + rnd) >>> quant_shift;
        end
`else
        r_ext = v_ext >>> quant_shift;
`endif
        if (r_ext > SAT_MAX) begin
            q_d = SAT_MAX[OUT_DATA_WIDTH-1:0];
        end else if (r_ext < SAT_MIN) begin
            q_d = SAT_MIN[OUT_DATA_WIDTH-1:0];
        end else begin
            q_d = r_ext[OUT_DATA_WIDTH-1:0];
        end
        if (!bn_result_valid) begin
            q_d = q_q;
        end
        q_valid_d = bn_result_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign fifo_pop = out_if.out_valid && out_if.out_ready;

    // layer_start resets the packer first so a same-cycle sample opens a fresh word.
    always_comb begin
        cnt_d      = cnt_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (layer_start) begin
            cnt_d      = '0;
            word_d     = '0;
            overflow_d = 1'b0;
        end
        filled = word_d;
        if (q_valid_q) begin
            for (int i = 0; i < PACK_NUM; i++) begin
                if (cnt_d == CW'(i)) begin
                    filled[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = q_q;
                end
            end
            if (cnt_d == CW'(PACK_NUM - 1)) begin
                push   = 1'b1;
                cnt_d  = '0;
                word_d = '0;
            end else begin
                cnt_d  = cnt_d + CW'(1);
                word_d = filled;
            end
        end
        push_word = filled;
        if (flush && !layer_start && !push && (cnt_d != '0)) begin
            push   = 1'b1;
            cnt_d  = '0;
            word_d = '0;
        end
        if (push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    act_pack_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_if.out_data  = fifo_dout;
    assign out_if.out_valid = !fifo_empty;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_bn_act_pack.sv
// Directed bench for bn_act_pack; expected words are hand-computed per build
// (BN_ACT_PACK_ROUND_EN changes the rounding-sensitive lanes).
module tb_bn_act_pack;
    import bn_act_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] bn_output_data = '0;
    logic               bn_result_valid = 1'b0;
    logic               relu_enable_layer = 1'b0;
    logic [4:0]         quant_shift = '0;
    logic               layer_start = 1'b0;
    logic               flush = 1'b0;
    logic               overflow;
    int                 tests_run = 0;
    int                 tests_failed = 0;

    bn_act_pack_if #(.WORD_WIDTH(32)) out_if ();

    bn_act_pack dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bn_output_data    (bn_output_data),
        .bn_result_valid   (bn_result_valid),
        .relu_enable_layer (relu_enable_layer),
        .quant_shift       (quant_shift),
        .layer_start       (layer_start),
        .flush             (flush),
        .out_if            (out_if),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] x);
        bn_output_data  = x;
        bn_result_valid = 1'b1;
        tick();
        bn_result_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        out_if.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %0b want 0", out_if.out_valid);
        end
        tests_run++;
        if (out_if.out_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h want 00000000", out_if.out_data);
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_overflow: got %0b want 0", overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_pack();
        logic [31:0] exp_word;
`ifdef BN_ACT_PACK_ROUND_EN
        exp_word = 32'h027F0010;
`else
        exp_word = 32'h017F0010;
`endif
        relu_enable_layer = 1'b1;
        quant_shift       = 5'd4;
        send(16'sd256);
        send(-16'sd50);
        send(16'sd32767);
        send(16'sd24);
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency_early: out_valid got %0b want 0", out_if.out_valid);
        end
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: out_valid got %0b want 1", out_if.out_valid);
        end
        tests_run++;
        if (out_if.out_data !== exp_word) begin
            tests_failed++;
            $display("[TB] FAIL basic_word: got %h want %h", out_if.out_data, exp_word);
        end
        pop_one();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_drained: out_valid got %0b want 0", out_if.out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_word;
`ifdef BN_ACT_PACK_ROUND_EN
        exp_word = 32'h7F7FFF80;
`else
        exp_word = 32'h7F7FFE80;
`endif
        relu_enable_layer = 1'b0;
        quant_shift       = 5'd1;
        send(-16'sd300);
        send(-16'sd3);
        send(16'sd255);
        send(16'sd254);
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_word) begin
            tests_failed++;
            $display("[TB] FAIL saturation_word: got valid=%0b %h want valid=1 %h",
                     out_if.out_valid, out_if.out_data, exp_word);
        end
        pop_one();
    endtask

    task automatic test_back_pressure();
        relu_enable_layer = 1'b0;
        quant_shift       = 5'd0;
        out_if.out_ready  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            send(16'(i));
        end
        repeat (2) tick();
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_overflow_set: got %0b want 1", overflow);
        end
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h04030201) begin
            tests_failed++;
            $display("[TB] FAIL bp_head_held: got valid=%0b %h want valid=1 04030201",
                     out_if.out_valid, out_if.out_data);
        end
        out_if.out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h08070605) begin
            tests_failed++;
            $display("[TB] FAIL bp_second_word: got valid=%0b %h want valid=1 08070605",
                     out_if.out_valid, out_if.out_data);
        end
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_only_two: out_valid got %0b want 0", out_if.out_valid);
        end
        out_if.out_ready = 1'b0;
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_overflow_sticky: got %0b want 1", overflow);
        end
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_overflow_clear: got %0b want 0", overflow);
        end
    endtask

    task automatic test_flush();
        send(16'sd5);
        send(16'sd6);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h00000605) begin
            tests_failed++;
            $display("[TB] FAIL flush_partial: got valid=%0b %h want valid=1 00000605",
                     out_if.out_valid, out_if.out_data);
        end
        pop_one();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty: out_valid got %0b want 0", out_if.out_valid);
        end
        send(16'sd7);
        send(16'sd8);
        send(16'sd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h00090807) begin
            tests_failed++;
            $display("[TB] FAIL flush_coincident: got valid=%0b %h want valid=1 00090807",
                     out_if.out_valid, out_if.out_data);
        end
        pop_one();
        repeat (2) tick();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_single_push: out_valid got %0b want 0", out_if.out_valid);
        end
    endtask

    task automatic test_layer_start();
        send(16'sd1);
        send(16'sd2);
        send(16'sd3);
        tick();
        send(16'sd16);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        send(16'sd17);
        send(16'sd18);
        send(16'sd19);
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h13121110) begin
            tests_failed++;
            $display("[TB] FAIL layer_start_word: got valid=%0b %h want valid=1 13121110",
                     out_if.out_valid, out_if.out_data);
        end
        pop_one();
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL layer_start_no_old: out_valid got %0b want 0", out_if.out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_if.out_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            send(16'(i));
        end
        repeat (2) tick();
        tests_run++;
        if (overflow !== 1'b1 || out_if.out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_precondition: got overflow=%0b valid=%0b want 1 1",
                     overflow, out_if.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async_valid: got %0b want 0", out_if.out_valid);
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async_overflow: got %0b want 0", overflow);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send(16'sd33);
        send(16'sd34);
        send(16'sd35);
        send(16'sd36);
        tick();
        tests_run++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 32'h24232221) begin
            tests_failed++;
            $display("[TB] FAIL rst_clean_word: got valid=%0b %h want valid=1 24232221",
                     out_if.out_valid, out_if.out_data);
        end
        pop_one();
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        test_reset();
        test_basic_pack();
        test_saturation();
        test_back_pressure();
        test_flush();
        test_layer_start();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
